// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the program counter, reads program memory over a
// req/ready handshake and holds one instruction at a time for the control unit.
module instr_fetch #(
  parameter int                  PC_WIDTH = 8,
  parameter int                  IR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                halt_i,
  output logic [PC_WIDTH-1:0] mem_addr_o,
  output logic                mem_rd_o,
  input  logic [IR_WIDTH-1:0] mem_rdata_i,
  input  logic                mem_ready_i,
  output logic [IR_WIDTH-1:0] ir_data_o,
  output logic [PC_WIDTH-1:0] ir_pc_o,
  output logic                ir_valid_o,
  input  logic                ir_ack_i,
  input  logic                br_taken_i,
  input  logic [PC_WIDTH-1:0] br_target_i,
  output logic [PC_WIDTH-1:0] pc_o
);

  // state   | meaning
  // IDLE    | paused, no memory request
  // FETCH   | mem_rd high, waiting for mem_ready at address pc
  // FULL    | instruction held on ir_data, waiting for ir_ack
  // HALTED  | stopped until reset, every other input ignored
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_FULL   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  logic [1:0]          state_q,    state_d;
  logic [PC_WIDTH-1:0] pc_q,       pc_d;
  logic [IR_WIDTH-1:0] ir_data_q,  ir_data_d;
  logic [PC_WIDTH-1:0] ir_pc_q,    ir_pc_d;
  logic                ir_valid_q, ir_valid_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_data_d  = ir_data_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;

    // A branch overrides everything outside HALTED, dropping any coincident word.
    if (state_q != S_HALTED && br_taken_i) begin
      pc_d       = br_target_i;
      ir_valid_d = 1'b0;
      state_d    = en_i ? S_FETCH : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (halt_i)    state_d = S_HALTED;
          else if (en_i) state_d = S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready_i) begin
            ir_data_d  = mem_rdata_i;
            ir_pc_d    = pc_q;
            pc_d       = pc_q + 1'b1;
            ir_valid_d = 1'b1;
            state_d    = S_FULL;
          end
        end
        S_FULL: begin
          if (ir_ack_i && ir_valid_q) begin
            ir_valid_d = 1'b0;
            if (halt_i)    state_d = S_HALTED;
            else if (en_i) state_d = S_FETCH;
            else           state_d = S_IDLE;
          end
        end
        S_HALTED: ir_valid_d = 1'b0;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_data_q  <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_data_q  <= ir_data_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  assign mem_rd_o   = (state_q == S_FETCH);
  assign mem_addr_o = pc_q;
  assign pc_o       = pc_q;
  assign ir_data_o  = ir_data_q;
  assign ir_pc_o    = ir_pc_q;
  assign ir_valid_o = ir_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: cycle vector table, then scoreboarded sequences with a
// latency-programmable memory and delayed-ack control unit.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst, en, halt, mem_ready, ir_ack, br;
  logic [15:0] mem_rdata;
  logic [7:0]  brt;
  logic [7:0]  mem_addr_o, ir_pc_o, pc_o;
  logic        mem_rd_o, ir_valid_o;
  logic [15:0] ir_data_o;

  always #5 clk = ~clk;

  instr_fetch #(.PC_WIDTH(8), .IR_WIDTH(16), .RESET_PC(8'h00)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .halt_i(halt),
    .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o), .mem_rdata_i(mem_rdata),
    .mem_ready_i(mem_ready), .ir_data_o(ir_data_o), .ir_pc_o(ir_pc_o),
    .ir_valid_o(ir_valid_o), .ir_ack_i(ir_ack), .br_taken_i(br),
    .br_target_i(brt), .pc_o(pc_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] word(input logic [7:0] a);
    return {~a, a};
  endfunction

  typedef struct {
    logic       rst, en, rdy;
    logic [15:0] rdata;
    logic       ack, br;
    logic [7:0] brt;
    logic       e_rd;
    logic [7:0] e_addr;
    logic       e_v;
    logic [15:0] e_data;
    logic [7:0] e_irpc, e_pc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic e, input logic rdy, input logic [15:0] rd,
                              input logic a, input logic b, input logic [7:0] bt,
                              input logic erd, input logic [7:0] ea, input logic ev,
                              input logic [15:0] ed, input logic [7:0] eip, input logic [7:0] epc);
    vec_t v;
    v.rst = r; v.en = e; v.rdy = rdy; v.rdata = rd; v.ack = a; v.br = b; v.brt = bt;
    v.e_rd = erd; v.e_addr = ea; v.e_v = ev; v.e_data = ed; v.e_irpc = eip; v.e_pc = epc;
    return v;
  endfunction

  // Memory / control-unit models and the expected-PC scoreboard
  bit          auto_mem = 0, auto_ack = 0, halted_exp = 0;
  int          lat = 0, ack_dly = 0, fcnt = 0, vcnt = 0;
  logic [7:0]  last_addr = 8'h00, exp_pc = 8'h00;
  logic [23:0] sb[$];
  logic [7:0]  seen[$];

  task automatic cyc();
    logic pv, pack, pbr, prst, pready, pmrd;
    logic [15:0] pdata;
    logic [7:0]  paddr;
    logic [23:0] e;
    if (auto_mem) begin
      if (mem_rd_o) begin
        if (mem_addr_o != last_addr) fcnt = 0;
        fcnt++;
        mem_ready = (fcnt == lat + 1);
        mem_rdata = word(mem_addr_o);
      end else begin
        fcnt = 0;
        mem_ready = 1'b0;
      end
      last_addr = mem_addr_o;
    end
    if (auto_ack) begin
      if (ir_valid_o) begin
        vcnt++;
        ir_ack = (vcnt == ack_dly + 1);
      end else begin
        vcnt = 0;
        ir_ack = 1'b0;
      end
    end
    if (rst) begin
      exp_pc = 8'h00; halted_exp = 0; sb.delete();
    end else if (!halted_exp) begin
      if (br) exp_pc = brt;
      else begin
        if (mem_ready && mem_rd_o) begin
          sb.push_back({exp_pc, word(exp_pc)});
          exp_pc = exp_pc + 8'd1;
        end
        if (halt && ir_ack && ir_valid_o) halted_exp = 1;
      end
    end
    pv = ir_valid_o; pack = ir_ack && ir_valid_o; pbr = br; prst = rst;
    pready = mem_ready; pmrd = mem_rd_o; pdata = ir_data_o; paddr = mem_addr_o;
    @(posedge clk); #1;
    if (ir_valid_o && !pv) begin
      seen.push_back(ir_pc_o);
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL ir_unexpected actual=%h required=none", {ir_pc_o, ir_data_o});
      end else begin
        e = sb.pop_front();
        chk("ir_word", {ir_pc_o, ir_data_o}, e);
      end
    end
    if (ir_valid_o && pv && !pack && !pbr && !prst) chk("ir_hold", ir_data_o, pdata);
    if (mem_rd_o && pmrd && !pready && !pbr && !prst) chk("addr_stable", mem_addr_o, paddr);
    if (ir_valid_o) chk("rd_in_full", mem_rd_o, 0);
    chk("pc", pc_o, exp_pc);
  endtask

  task automatic wait_rd(input string name);
    for (int i = 0; i < 30 && !mem_rd_o; i++) cyc();
    chk(name, mem_rd_o, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
  endtask

  vec_t vt[$];

  initial begin
    rst = 1; en = 1; halt = 0; mem_ready = 0; ir_ack = 0; br = 0; brt = 0; mem_rdata = 0;

    vt.push_back(mk(1,1,0,16'h0000,0,0,8'h00, 0,8'h00,0,16'h0000,8'h00,8'h00));
    vt.push_back(mk(1,1,0,16'h0000,0,0,8'h00, 0,8'h00,0,16'h0000,8'h00,8'h00));
    vt.push_back(mk(0,1,0,16'h0000,0,0,8'h00, 1,8'h00,0,16'h0000,8'h00,8'h00));
    vt.push_back(mk(0,1,1,16'h0000,0,0,8'h00, 0,8'h00,1,16'h0000,8'h00,8'h01));
    vt.push_back(mk(0,1,0,16'h0000,1,0,8'h00, 1,8'h01,0,16'h0000,8'h00,8'h01));
    vt.push_back(mk(0,1,1,16'h0001,0,0,8'h00, 0,8'h00,1,16'h0001,8'h01,8'h02));
    vt.push_back(mk(0,1,0,16'h0000,1,0,8'h00, 1,8'h02,0,16'h0000,8'h00,8'h02));
    vt.push_back(mk(0,1,1,16'h0002,0,0,8'h00, 0,8'h00,1,16'h0002,8'h02,8'h03));
    vt.push_back(mk(0,1,0,16'h0000,1,0,8'h00, 1,8'h03,0,16'h0000,8'h00,8'h03));
    vt.push_back(mk(0,1,1,16'h0003,0,0,8'h00, 0,8'h00,1,16'h0003,8'h03,8'h04));
    vt.push_back(mk(0,0,0,16'h0000,1,0,8'h00, 0,8'h00,0,16'h0000,8'h00,8'h04));
    vt.push_back(mk(0,0,1,16'hBEEF,0,0,8'h00, 0,8'h00,0,16'h0000,8'h00,8'h04));
    vt.push_back(mk(0,1,0,16'h0000,0,0,8'h00, 1,8'h04,0,16'h0000,8'h00,8'h04));
    vt.push_back(mk(0,1,0,16'h0000,1,0,8'h00, 1,8'h04,0,16'h0000,8'h00,8'h04));
    vt.push_back(mk(0,1,1,16'h1234,0,0,8'h00, 0,8'h00,1,16'h1234,8'h04,8'h05));
    vt.push_back(mk(0,1,0,16'h0000,1,1,8'h20, 1,8'h20,0,16'h0000,8'h00,8'h20));
    vt.push_back(mk(0,0,0,16'h0000,0,1,8'h30, 0,8'h00,0,16'h0000,8'h00,8'h30));
    vt.push_back(mk(0,1,0,16'h0000,0,0,8'h00, 1,8'h30,0,16'h0000,8'h00,8'h30));

    foreach (vt[i]) begin
      rst = vt[i].rst; en = vt[i].en; mem_ready = vt[i].rdy; mem_rdata = vt[i].rdata;
      ir_ack = vt[i].ack; br = vt[i].br; brt = vt[i].brt;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i),
          {mem_rd_o, vt[i].e_rd ? mem_addr_o : 8'h00, ir_valid_o,
           vt[i].e_v ? ir_data_o : 16'h0000, vt[i].e_v ? ir_pc_o : 8'h00, pc_o},
          {vt[i].e_rd, vt[i].e_rd ? vt[i].e_addr : 8'h00, vt[i].e_v,
           vt[i].e_v ? vt[i].e_data : 16'h0000, vt[i].e_v ? vt[i].e_irpc : 8'h00, vt[i].e_pc});
      if (i == 1) chk("reset_ir", {ir_data_o, ir_pc_o, mem_addr_o}, 32'h0);
    end
    mem_ready = 0; ir_ack = 0; br = 0; en = 1;

    // wait states and backpressure
    lat = 3; ack_dly = 4; auto_mem = 1; auto_ack = 1;
    do_reset();
    seen.delete();
    repeat (40) cyc();
    chk("s1_progress", seen.size() >= 3, 1);

    // branch flush while FULL at ir_pc 5
    lat = 0; ack_dly = 0;
    do_reset();
    for (int i = 0; i < 60 && !(ir_valid_o && ir_pc_o == 8'd5); i++) cyc();
    chk("s2_reach5", {ir_valid_o, ir_pc_o}, {1'b1, 8'd5});
    auto_ack = 0; ir_ack = 0; br = 1; brt = 8'h40;
    cyc();
    br = 0; auto_ack = 1;
    chk("s2_flush", {ir_valid_o, mem_rd_o, mem_addr_o}, {1'b0, 1'b1, 8'h40});
    seen.delete();
    repeat (8) cyc();
    chk("s2_next40", seen.size() > 0 ? seen[0] : 8'hxx, 8'h40);

    // branch in FETCH with coincident mem_ready: word dropped
    auto_mem = 0; mem_ready = 0;
    wait_rd("s2b_fetch");
    mem_ready = 1; mem_rdata = word(mem_addr_o); br = 1; brt = 8'h80;
    cyc();
    mem_ready = 0; br = 0; auto_mem = 1;
    chk("s2b_drop", {ir_valid_o, mem_rd_o, mem_addr_o}, {1'b0, 1'b1, 8'h80});
    seen.delete();
    repeat (6) cyc();
    chk("s2b_next80", seen.size() > 0 ? seen[0] : 8'hxx, 8'h80);

    // wrap-around
    seen.delete();
    br = 1; brt = 8'hFE;
    cyc();
    br = 0;
    for (int i = 0; i < 40 && seen.size() < 3; i++) cyc();
    chk("wrap_n", seen.size() >= 3, 1);
    if (seen.size() >= 3) begin
      chk("wrap0", seen[0], 8'hFE);
      chk("wrap1", seen[1], 8'hFF);
      chk("wrap2", seen[2], 8'h00);
    end

    // halt raised in FETCH
    lat = 3; ack_dly = 2;
    do_reset();
    wait_rd("s4_fetch");
    halt = 1;
    for (int i = 0; i < 20 && !ir_valid_o; i++) cyc();
    chk("s4_full", ir_valid_o, 1);
    repeat (6) cyc();
    chk("s4_halted", {mem_rd_o, ir_valid_o}, 2'b00);
    br = 1; brt = 8'h33;
    cyc();
    br = 0; halt = 0;
    repeat (3) cyc();
    chk("s4_br_ignored", {mem_rd_o, ir_valid_o, pc_o}, {1'b0, 1'b0, 8'd1});

    // reset during a wait, then a late mem_ready
    do_reset();
    auto_mem = 0; mem_ready = 0;
    wait_rd("s5_fetch");
    br = 1; brt = 8'h10;
    cyc();
    br = 0;
    cyc();
    chk("s5_waiting", {mem_rd_o, mem_addr_o}, {1'b1, 8'h10});
    rst = 1;
    cyc();
    rst = 0;
    chk("s5_rst", {mem_rd_o, ir_valid_o, pc_o}, {1'b0, 1'b0, 8'h00});
    mem_ready = 1; mem_rdata = word(8'h10);
    cyc();
    mem_ready = 0;
    chk("s5_late_ignored", {ir_valid_o, mem_rd_o, mem_addr_o}, {1'b0, 1'b1, 8'h00});
    auto_mem = 1; lat = 0;
    seen.delete();
    repeat (6) cyc();
    chk("s5_resume0", seen.size() > 0 ? seen[0] : 8'hxx, 8'h00);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 16-bit processor: holds the program counter, reads instruction words from the program memory through a request/ready handshake, and presents one instruction at a time to the control unit on `ir_data`. The control unit consumes each word with `ir_ack` and redirects fetch with `br_taken`/`br_target`. Fetch stops on `halt`.

## Interface
- `PC_WIDTH`, 8, program counter and memory address width
- `IR_WIDTH`, 16, instruction word width (matches control unit `ir_data`)
- `RESET_PC`, 0, PC value loaded on reset

- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  run enable; low pauses fetch after the current instruction is consumed
- `halt`  in  1  level, from control unit; stops fetch permanently until reset
- `mem_addr`  out  PC_WIDTH  program memory address (= `pc` while fetching)
- `mem_rd`  out  1  memory read request, level
- `mem_rdata`  in  IR_WIDTH  memory read data, valid when `mem_ready`=1
- `mem_ready`  in  1  one-cycle pulse: `mem_rdata` holds the word at the current `mem_addr`
- `ir_data`  out  IR_WIDTH  instruction to control unit
- `ir_pc`  out  PC_WIDTH  address `ir_data` was fetched from
- `ir_valid`  out  1  `ir_data` valid
- `ir_ack`  in  1  control unit consumed `ir_data` (honoured only while `ir_valid`=1)
- `br_taken`  in  1  redirect fetch, one-cycle pulse
- `br_target`  in  PC_WIDTH  new PC when `br_taken`=1
- `pc`  out  PC_WIDTH  current program counter

## Operation
- States: IDLE, FETCH, FULL, HALTED. Priority: `rst` > `br_taken` > `halt` > normal flow.
- Reset: state IDLE, `pc`=RESET_PC, `mem_rd`=0, `mem_addr`=RESET_PC, `ir_valid`=0, `ir_data`=0, `ir_pc`=0. Applies regardless of state, including mid-fetch. An outstanding memory pulse after reset is ignored.
- IDLE: `mem_rd`=0. If `halt`, go to HALTED. Else if `en`, go to FETCH.
- FETCH: `mem_rd`=1, `mem_addr`=`pc` held stable. On `mem_ready`: `ir_data`<=`mem_rdata`, `ir_pc`<=`pc`, `pc`<=`pc`+1, `ir_valid`<=1, go to FULL. `halt` does not abort a fetch in progress.
- FULL: `mem_rd`=0, and `ir_data`/`ir_pc` are stable while `ir_valid`=1. On `ir_ack`, clear `ir_valid` and go to:
  - HALTED if `halt`
  - else FETCH if `en`
  - else IDLE
- HALTED: `mem_rd`=0, `ir_valid`=0. All inputs except `rst` are ignored, including `br_taken`.
- Branch (IDLE/FETCH/FULL):
  - `pc`<=`br_target` and `ir_valid`<=0, so a held instruction is flushed.
  - Any `mem_ready` in the same cycle is dropped.
  - Next state is FETCH if `en`, else IDLE.
  - `br_taken` together with `ir_ack` acts as a branch.
- Arithmetic: `pc`+1 wraps modulo 2^PC_WIDTH (255 -> 0 at default). `br_target` is taken unmodified.
- `ir_ack` while `ir_valid`=0 is ignored. `mem_ready` outside FETCH is ignored.

## Timing
- From reset release with `en`=1: cycle 1 IDLE, cycle 2 FETCH with `mem_rd`=1 and `mem_addr`=RESET_PC.
- `mem_ready` at cycle k gives `ir_valid`=1 from cycle k+1, and `pc` increments at the same edge.
- `ir_ack` at cycle j gives `ir_valid`=0 at j+1; with `en`=1, FETCH is also entered at j+1 (`mem_rd`=1, new address).
- Minimum issue interval is one memory latency plus 2 cycles. Zero-wait memory (`mem_ready` in the first FETCH cycle) gives one instruction per 2 cycles when acked immediately.
- `br_taken` at cycle b gives `mem_addr`=`br_target` and `mem_rd`=1 at b+1 (with `en`=1).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset/sequential fetch:
  - Stimulus: `rst` 2 cycles, `en`=1, zero-wait memory returning word = address, immediate `ir_ack`.
  - Required: `ir_data`/`ir_pc` sequence 0,1,2,3, `ir_valid` pulses every 2nd cycle, `pc` ends at 4.
- Wait states and backpressure:
  - Stimulus: memory returns after 3 cycles, and `ir_ack` is delayed 4 cycles.
  - Required: `mem_addr` stable throughout FETCH, `ir_data` unchanged while unacked, `mem_rd`=0 during FULL.
- Branch flush:
  - Stimulus: in FULL with `ir_pc`=5, pulse `br_taken` with `br_target`=0x40.
  - Required: `ir_valid`=0 next cycle, the next fetch is at 0x40, and instruction 5 is never re-presented.
  - Also: repeat during FETCH with a coincident `mem_ready`; the word is dropped.
- Wrap-around:
  - Stimulus: branch to 0xFE, run 3 instructions.
  - Required: `ir_pc` sequence 0xFE, 0xFF, 0x00.
- Halt/pause:
  - Stimulus: raise `halt` in FETCH.
  - Required: the fetch completes to FULL. After `ir_ack` the block enters HALTED with `mem_rd`=0, and a later `br_taken` has no effect.
  - Also: `en`=0 at ack goes to IDLE; `en`=1 then resumes at the next sequential `pc`.
- Reset mid-fetch:
  - Stimulus: assert `rst` during a 3-cycle wait.
  - Required: next cycle `mem_rd`=0 and `pc`=RESET_PC, and the late `mem_ready` is ignored.
